// File: rtl/mdu_hilo_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a start/busy handshake.
// Optional multiply-accumulate opcodes (madd/maddu/msub/msubu) are built when MDU_MADD_EN is defined.
module mdu_hilo_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        req,
    input  logic [3:0]  MDUCtrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Sign-extending to 64 bits makes the low half of an unsigned multiply the signed product.
    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed division runs on magnitudes so the INT_MIN / -1 case is well defined.
    logic [31:0] abs_a, abs_b, div_b, sdiv_b;
    logic [31:0] uq, ur, sq_mag, sr_mag, sq, sr;
    logic        b_zero;
    assign b_zero = (B == 32'd0);
    assign abs_a  = A[31] ? -A : A;
    assign abs_b  = B[31] ? -B : B;
    assign div_b  = b_zero ? 32'd1 : B;
    assign sdiv_b = b_zero ? 32'd1 : abs_b;
    assign uq     = A / div_b;
    assign ur     = A % div_b;
    assign sq_mag = abs_a / sdiv_b;
    assign sr_mag = abs_a % sdiv_b;
    assign sq     = (A[31] ^ B[31]) ? -sq_mag : sq_mag;
    assign sr     = A[31] ? -sr_mag : sr_mag;

    logic        is_mult, is_div, accept;
    logic [63:0] result;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        is_mult = 1'b0;
        is_div  = 1'b0;
        result  = {hi_q, lo_q};
        case (MDUCtrl)
            OP_MULT:  begin is_mult = 1'b1; result = prod_s; end
            OP_MULTU: begin is_mult = 1'b1; result = prod_u; end
            OP_DIV:   begin is_div = 1'b1; if (!b_zero) result = {sr, sq}; end
            OP_DIVU:  begin is_div = 1'b1; if (!b_zero) result = {ur, uq}; end
`ifdef MDU_MADD_EN
            OP_MADD:  begin is_mult = 1'b1; result = {hi_q, lo_q} + prod_s; end
            OP_MADDU: begin is_mult = 1'b1; result = {hi_q, lo_q} + prod_u; end
            OP_MSUB:  begin is_mult = 1'b1; result = {hi_q, lo_q} - prod_s; end
            OP_MSUBU: begin is_mult = 1'b1; result = {hi_q, lo_q} - prod_u; end
`endif
            default:  ;
        endcase
    end

    assign accept = (state_q == ST_IDLE) && start && !req && (is_mult || is_div);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                pend_d  = result;
                cnt_d   = is_mult ? 5'(MULT_CYCLES) : 5'(DIV_CYCLES);
                state_d = ST_RUN;
            end else if (!req && MDUCtrl == OP_MTHI) begin
                hi_d = A;
            end else if (!req && MDUCtrl == OP_MTLO) begin
                lo_d = A;
            end
        end else begin
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                {hi_d, lo_d} = pend_q;
                state_d      = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            pend_q  <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Self-checking bench for mdu_hilo_unit: directed vector table, hand-written corner sequences,
// and randomized operations against an arithmetic reference model (honours MDU_MADD_EN).
module tb_mdu_hilo_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        req = 1'b0;
    logic [3:0]  MDUCtrl = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] HI, LO;

    mdu_hilo_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .req(req), .MDUCtrl(MDUCtrl),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] m_hi, m_lo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic issue(input logic [3:0] op, input logic st, input logic rq,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = st; req = rq; MDUCtrl = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; req = 1'b0; MDUCtrl = 4'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    function automatic int latency(input logic [3:0] op, input logic st, input logic rq);
        if (rq || !st) return 0;
        if (op == 4'd1 || op == 4'd2) return 5;
        if (op == 4'd3 || op == 4'd4) return 10;
`ifdef MDU_MADD_EN
        if (op >= 4'd7 && op <= 4'd10) return 5;
`endif
        return 0;
    endfunction

    // Reference model: applies one accepted operation to m_hi/m_lo using plain integer arithmetic.
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint ps;
        longint unsigned ua, ub, pu, acc;
        sa = a; sb = b; ua = a; ub = b;
        ps = longint'(sa) * longint'(sb);
        pu = ua * ub;
        acc = {m_hi, m_lo};
        case (op)
            4'd1: {m_hi, m_lo} = ps;
            4'd2: {m_hi, m_lo} = pu;
            4'd3: if (sb != 0) begin
                      if (a == 32'h8000_0000 && sb == -1) begin m_lo = a; m_hi = 0; end
                      else begin m_lo = sa / sb; m_hi = sa % sb; end
                  end
            4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
`ifdef MDU_MADD_EN
            4'd7:  {m_hi, m_lo} = acc + ps;
            4'd8:  {m_hi, m_lo} = acc + pu;
            4'd9:  {m_hi, m_lo} = acc - ps;
            4'd10: {m_hi, m_lo} = acc - pu;
`endif
            default: ;
        endcase
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        st;
        logic        rq;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    initial begin
        int n, n2;
        logic seen_busy;
        logic [3:0] op;
        logic rq;
        logic [31:0] a, b;

        vecs[0]  = '{4'd1,  1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3,          5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{4'd2,  1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3,          5,  32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2]  = '{4'd3,  1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2,          10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{4'd4,  1'b1, 1'b0, 32'd7,         32'd0,          10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{4'd5,  1'b1, 1'b0, 32'h1234_5678, 32'd0,          0,  32'h1234_5678, 32'hFFFF_FFFD};
        vecs[5]  = '{4'd6,  1'b1, 1'b0, 32'h9ABC_DEF0, 32'd0,          0,  32'h1234_5678, 32'h9ABC_DEF0};
        vecs[6]  = '{4'd1,  1'b1, 1'b1, 32'd5,         32'd5,          0,  32'h1234_5678, 32'h9ABC_DEF0};
        vecs[7]  = '{4'd5,  1'b0, 1'b0, 32'hCAFE_F00D, 32'd0,          0,  32'hCAFE_F00D, 32'h9ABC_DEF0};
        vecs[8]  = '{4'd3,  1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,  10, 32'h0000_0000, 32'h8000_0000};
        vecs[9]  = '{4'd11, 1'b1, 1'b0, 32'd9,         32'd9,          0,  32'h0000_0000, 32'h8000_0000};
        vecs[10] = '{4'd0,  1'b1, 1'b0, 32'd9,         32'd9,          0,  32'h0000_0000, 32'h8000_0000};
        vecs[11] = '{4'd6,  1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0,          0,  32'h0000_0000, 32'hFFFF_FFFF};
`ifdef MDU_MADD_EN
        vecs[12] = '{4'd8,  1'b1, 1'b0, 32'd1,         32'd1,          5,  32'h0000_0001, 32'h0000_0000};
`else
        vecs[12] = '{4'd8,  1'b1, 1'b0, 32'd1,         32'd1,          0,  32'h0000_0000, 32'hFFFF_FFFF};
`endif

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_hi", HI, 0);
        check("reset_lo", LO, 0);

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].st, vecs[i].rq, vecs[i].a, vecs[i].b);
            wait_idle(n);
            check($sformatf("vec%0d_cycles", i), n, vecs[i].cyc);
            check($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
        end

        // mthi while a mult is running is ignored.
        issue(4'd1, 1'b1, 1'b0, 32'd3, 32'd4);
        MDUCtrl = 4'd5; A = 32'hDEAD_BEEF;
        @(negedge clk);
        MDUCtrl = 4'd0;
        wait_idle(n);
        check("mthi_in_run_cycles", n + 1, 5);
        check("mthi_in_run_hi", HI, 0);
        check("mthi_in_run_lo", LO, 12);

        // req during RUN does not abort.
        issue(4'd1, 1'b1, 1'b0, 32'd5, 32'd5);
        req = 1'b1;
        repeat (2) @(negedge clk);
        req = 1'b0;
        wait_idle(n);
        check("req_in_run_cycles", n + 2, 5);
        check("req_in_run_lo", LO, 25);
        check("req_in_run_hi", HI, 0);

        // Reset in the third busy cycle of a div: no later commit.
        issue(4'd3, 1'b1, 1'b0, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_hi", HI, 0);
        check("mid_reset_lo", LO, 0);
        seen_busy = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy || HI != 0 || LO != 0) seen_busy = 1'b1;
        end
        check("no_commit_after_reset", seen_busy, 0);

        // A second start while busy is dropped.
        issue(4'd1, 1'b1, 1'b0, 32'd7, 32'd6);
        start = 1'b1; MDUCtrl = 4'd3; A = 32'd1; B = 32'd1;
        @(negedge clk);
        start = 1'b0; MDUCtrl = 4'd0;
        wait_idle(n);
        check("second_start_cycles", n + 1, 5);
        check("second_start_lo", LO, 42);
        check("second_start_hi", HI, 0);
        repeat (3) @(negedge clk);
        check("second_start_no_rerun", busy, 0);

        m_hi = 32'd0;
        m_lo = 32'd42;
        for (int i = 0; i < 200; i++) begin
`ifdef MDU_MADD_EN
            op = 4'($urandom_range(1, 10));
`else
            op = 4'($urandom_range(1, 6));
`endif
            rq = ($urandom_range(0, 7) == 0);
            a = $urandom;
            b = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'($signed(16'($urandom)));
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            issue(op, 1'b1, rq, a, b);
            wait_idle(n2);
            if (!rq) model_op(op, a, b);
            check($sformatf("rand%0d_op%0d_cycles", i, op), n2, latency(op, 1'b1, rq));
            check($sformatf("rand%0d_op%0d_hilo", i, op), {HI, LO}, {m_hi, m_lo});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
